// File: rtl/axi_modport_pkg.sv
// Shared constants, FSM state types and burst address stepping for the
// axi_modport memory responder.
package axi_modport_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Address of the beat following addr. WRAP keeps the upper bits of the
    // aligned (len+1)*bytes window and lets only the low bits roll over.
    function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [63:0] bytes;
        logic [63:0] incr;
        logic [63:0] wrap_mask;
        bytes     = 64'd1 << size;
        incr      = addr + bytes;
        wrap_mask = (({56'd0, len} + 64'd1) * bytes) - 64'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:     next_addr = incr;
        endcase
    endfunction

endpackage

// File: rtl/axi_modport_mem.sv
// Word memory: one byte-enabled write port, one combinational read port.
// A read of the word being written in the same cycle returns the old data.
module axi_modport_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int IDX_W      = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Byte-lane write; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_modport.sv
// AXI slave memory responder: independent write and read paths, one
// transaction outstanding on each, all outputs registered.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, storing awlen+1 beats
// W_RESP | bvalid high, holding bid/bresp until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, presenting beats until the last one is taken
//
// aresetn is a synchronous, active-HIGH reset despite its name.
module axi_modport
    import axi_modport_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [3:0]              awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [3:0]              wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [3:0]              bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [3:0]              arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [3:0]              rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int WIDX_W = ADDR_WIDTH - OFF;
    localparam logic [WIDX_W-1:0] DEPTH_W = WIDX_W'(MEM_DEPTH);

    function automatic logic beat_oob(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:OFF] >= DEPTH_W;
    endfunction

    // Request-level faults; these poison every beat of the burst.
    function automatic logic req_bad(input logic [2:0] size,
                                     input logic [7:0] len,
                                     input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || (size > 3'(OFF)) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic [2:0] size,
                                                   input logic [7:0] len,
                                                   input logic [1:0] burst);
        return ADDR_WIDTH'(next_addr(64'(a), size, len, burst));
    endfunction

    logic unused_wid;
    assign unused_wid = ^wid;

    // ---------------- write path ----------------
    w_state_e              w_state_q, w_state_d;
    logic [3:0]            aw_id_q, aw_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [2:0]            w_size_q, w_size_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic [7:0]            w_left_q, w_left_d;
    logic                  w_req_err_q, w_req_err_d;
    logic                  w_err_q, w_err_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [3:0]            bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we;
    logic                  w_beat_err;
    logic                  w_last;

    // Write FSM: latch AW, count beats down to zero, then hold the response.
    always_comb begin
        w_state_d   = w_state_q;
        aw_id_d     = aw_id_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_size_d    = w_size_q;
        w_burst_d   = w_burst_q;
        w_left_d    = w_left_q;
        w_req_err_d = w_req_err_q;
        w_err_d     = w_err_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        mem_we      = 1'b0;
        w_beat_err  = w_req_err_q || beat_oob(w_addr_q);
        w_last      = (w_left_q == 8'd0);
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    aw_id_d     = awid;
                    w_addr_d    = awaddr;
                    w_len_d     = awlen;
                    w_size_d    = awsize;
                    w_burst_d   = awburst;
                    w_left_d    = awlen;
                    w_req_err_d = req_bad(awsize, awlen, awburst);
                    w_err_d     = 1'b0;
                    w_state_d   = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    // A misplaced wlast is reported but the data still lands.
                    mem_we   = !w_beat_err;
                    w_err_d  = w_err_q || w_beat_err || (wlast != w_last);
                    w_addr_d = step(w_addr_q, w_size_q, w_len_q, w_burst_q);
                    if (w_last) begin
                        w_state_d = W_RESP;
                        bid_d     = aw_id_q;
                        bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_left_d = w_left_q - 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Write-path registers.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            w_state_q   <= W_IDLE;
            aw_id_q     <= '0;
            w_addr_q    <= '0;
            w_len_q     <= '0;
            w_size_q    <= '0;
            w_burst_q   <= '0;
            w_left_q    <= '0;
            w_req_err_q <= 1'b0;
            w_err_q     <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= '0;
        end else begin
            w_state_q   <= w_state_d;
            aw_id_q     <= aw_id_d;
            w_addr_q    <= w_addr_d;
            w_len_q     <= w_len_d;
            w_size_q    <= w_size_d;
            w_burst_q   <= w_burst_d;
            w_left_q    <= w_left_d;
            w_req_err_q <= w_req_err_d;
            w_err_q     <= w_err_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
        end
    end

    // ---------------- read path ----------------
    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [2:0]            r_size_q, r_size_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [7:0]            r_left_q, r_left_d;
    logic                  r_req_err_q, r_req_err_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [3:0]            rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  r_load;
    logic                  r_beat_err;
    logic [IDX_W-1:0]      mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Read FSM: r_addr_d always points at the beat to present next, so the
    // memory is looked up one cycle ahead and rdata stays registered.
    always_comb begin
        r_state_d   = r_state_q;
        r_addr_d    = r_addr_q;
        r_len_d     = r_len_q;
        r_size_d    = r_size_q;
        r_burst_d   = r_burst_q;
        r_left_d    = r_left_q;
        r_req_err_d = r_req_err_q;
        rid_d       = rid_q;
        rlast_d     = rlast_q;
        r_load      = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    r_addr_d    = araddr;
                    r_len_d     = arlen;
                    r_size_d    = arsize;
                    r_burst_d   = arburst;
                    r_left_d    = arlen;
                    r_req_err_d = req_bad(arsize, arlen, arburst);
                    rid_d       = arid;
                    rlast_d     = (arlen == 8'd0);
                    r_load      = 1'b1;
                    r_state_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (r_left_q == 8'd0) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = step(r_addr_q, r_size_q, r_len_q, r_burst_q);
                        r_left_d = r_left_q - 8'd1;
                        rlast_d  = (r_left_q == 8'd1);
                        r_load   = 1'b1;
                    end
                end
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    assign mem_raddr = r_addr_d[OFF +: IDX_W];

    // Beat data/response for the next presented beat; faulty beats read as 0.
    always_comb begin
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        r_beat_err = r_req_err_d || beat_oob(r_addr_d);
        if (r_load) begin
            rdata_d = r_beat_err ? '0 : mem_rdata;
            rresp_d = r_beat_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Read-path registers.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            r_state_q   <= R_IDLE;
            r_addr_q    <= '0;
            r_len_q     <= '0;
            r_size_q    <= '0;
            r_burst_q   <= '0;
            r_left_q    <= '0;
            r_req_err_q <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            rlast_q     <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            r_addr_q    <= r_addr_d;
            r_len_q     <= r_len_d;
            r_size_q    <= r_size_d;
            r_burst_q   <= r_burst_d;
            r_left_q    <= r_left_d;
            r_req_err_q <= r_req_err_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
        end
    end

    axi_modport_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (aclk),
        .we    (mem_we),
        .waddr (w_addr_q[OFF +: IDX_W]),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_modport.sv
// Directed bench for axi_modport: bursts, strobes, error responses,
// backpressure and mid-burst reset.
module tb_axi_modport;
    import axi_modport_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id [16];
    int          rd_n;

    always #5 aclk = ~aclk;

    axi_modport dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (awready !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL aw_timeout: awready=%b, required 1", awready);
        end
        tick();
        awvalid = 1'b0;
    endtask

    // wl_mode 0: wlast on final beat, 1: never, 2: on every beat
    task automatic send_w(input logic [7:0] len, input logic [3:0] strb, input int wl_mode);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            wdata = wbuf[i]; wstrb = strb; wvalid = 1'b1;
            case (wl_mode)
                0:       wlast = (i == int'(len));
                1:       wlast = 1'b0;
                default: wlast = 1'b1;
            endcase
            while (wready !== 1'b1 && n < 50) begin tick(); n++; end
            if (n >= 50) begin
                n_tests++; n_fail++;
                $display("FAIL w_timeout: wready=%b, required 1 (beat %0d)", wready, i);
            end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic get_b(output logic [3:0] got_id, output logic [1:0] got_resp);
        int n = 0;
        bready = 1'b1;
        while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL b_timeout: bvalid=%b, required 1", bvalid);
        end
        got_id = bid; got_resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                               input int wl_mode, output logic [3:0] got_id, output logic [1:0] got_resp);
        send_aw(id, addr, len, size, burst);
        send_w(len, strb, wl_mode);
        get_b(got_id, got_resp);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (arready !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL ar_timeout: arready=%b, required 1", arready);
        end
        tick();
        arvalid = 1'b0;
    endtask

    // rr_mode 0: rready always high, 1: rready toggles starting low
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int rr_mode);
        int cyc = 0;
        send_ar(id, addr, len, size, burst);
        rd_n = 0;
        while (rd_n < int'(len) + 1 && cyc < 200) begin
            rready = (rr_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            if (rvalid === 1'b1 && rready) begin
                rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp;
                rd_last[rd_n] = rlast; rd_id[rd_n] = rid;
                rd_n++;
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        if (cyc >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL r_timeout: beats=%0d, required %0d", rd_n, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: aw=%b w=%b b=%b bid=%h bresp=%b ar=%b r=%b rid=%h rdata=%h rresp=%b rlast=%b, required all 0",
                     awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast);
        end
        aresetn = 1'b0;
        tick();
        n_tests++;
        if (awready !== 1'b1 || arready !== 1'b1 || wready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: awready=%b arready=%b wready=%b, required 1 1 0", awready, arready, wready);
        end
    endtask

    task automatic test_incr();
        logic [3:0] b_id; logic [1:0] b_resp;
        logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 4; i++) wbuf[i] = exp_d[i];
        write_burst(4'd3, 32'h10, 8'd3, 3'd2, BURST_INCR, 4'hF, 0, b_id, b_resp);
        n_tests++;
        if (b_id !== 4'd3 || b_resp !== 2'b00) begin
            n_fail++; $display("FAIL incr_b: bid=%h bresp=%b, required 3 00", b_id, b_resp);
        end
        read_burst(4'd5, 32'h10, 8'd3, 3'd2, BURST_INCR, 0);
        n_tests++;
        if (rd_n != 4) begin n_fail++; $display("FAIL incr_count: beats=%0d, required 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd_data[i] !== exp_d[i] || rd_id[i] !== 4'd5 || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL incr_beat%0d: rdata=%h rid=%h rresp=%b rlast=%b, required %h 5 00 %b",
                         i, rd_data[i], rd_id[i], rd_resp[i], rd_last[i], exp_d[i], (i == 3));
            end
        end
        n_tests++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_fail++; $display("FAIL incr_end: rvalid=%b arready=%b, required 0 1", rvalid, arready);
        end
    endtask

    task automatic test_wrap_read();
        logic [3:0] b_id; logic [1:0] b_resp;
        logic [31:0] exp_d [4] = '{32'hB2, 32'hB3, 32'hB0, 32'hB1};
        wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2; wbuf[3] = 32'hB3;
        write_burst(4'd1, 32'h30, 8'd3, 3'd2, BURST_INCR, 4'hF, 0, b_id, b_resp);
        read_burst(4'd6, 32'h38, 8'd3, 3'd2, BURST_WRAP, 0);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd_data[i] !== exp_d[i] || rd_resp[i] !== 2'b00) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: rdata=%h rresp=%b, required %h 00", i, rd_data[i], rd_resp[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_fixed();
        logic [3:0] b_id; logic [1:0] b_resp;
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
        write_burst(4'd2, 32'h20, 8'd2, 3'd2, BURST_FIXED, 4'hF, 0, b_id, b_resp);
        n_tests++;
        if (b_resp !== 2'b00) begin n_fail++; $display("FAIL fixed_bresp: %b, required 00", b_resp); end
        read_burst(4'd0, 32'h20, 8'd0, 3'd2, BURST_INCR, 0);
        n_tests++;
        if (rd_data[0] !== 32'd3) begin n_fail++; $display("FAIL fixed_data: %h, required 00000003", rd_data[0]); end
    endtask

    task automatic test_strobe();
        logic [3:0] b_id; logic [1:0] b_resp;
        wbuf[0] = 32'h11223344;
        write_burst(4'd0, 32'h40, 8'd0, 3'd2, BURST_INCR, 4'hF, 0, b_id, b_resp);
        wbuf[0] = 32'hDEADBEEF;
        write_burst(4'd0, 32'h40, 8'd0, 3'd2, BURST_INCR, 4'h3, 0, b_id, b_resp);
        read_burst(4'd0, 32'h40, 8'd0, 3'd2, BURST_INCR, 0);
        n_tests++;
        if (rd_data[0] !== 32'h1122BEEF) begin n_fail++; $display("FAIL strobe_data: %h, required 1122beef", rd_data[0]); end
    endtask

    task automatic test_errors();
        logic [3:0] b_id; logic [1:0] b_resp;
        wbuf[0] = 32'h55AA55AA;
        write_burst(4'd0, 32'h0, 8'd0, 3'd2, BURST_INCR, 4'hF, 0, b_id, b_resp);
        wbuf[0] = 32'hFFFFFFFF;
        write_burst(4'd7, 32'h400, 8'd0, 3'd2, BURST_INCR, 4'hF, 0, b_id, b_resp);
        n_tests++;
        if (b_resp !== 2'b10 || b_id !== 4'd7) begin
            n_fail++; $display("FAIL oob_write_bresp: bid=%h bresp=%b, required 7 10", b_id, b_resp);
        end
        read_burst(4'd0, 32'h0, 8'd0, 3'd2, BURST_INCR, 0);
        n_tests++;
        if (rd_data[0] !== 32'h55AA55AA || rd_resp[0] !== 2'b00) begin
            n_fail++; $display("FAIL oob_write_mem: rdata=%h rresp=%b, required 55aa55aa 00", rd_data[0], rd_resp[0]);
        end
        // burst crossing the end of memory: first beat lands, second is dropped
        wbuf[0] = 32'hC0; wbuf[1] = 32'hC1;
        write_burst(4'd0, 32'h3FC, 8'd1, 3'd2, BURST_INCR, 4'hF, 0, b_id, b_resp);
        n_tests++;
        if (b_resp !== 2'b10) begin n_fail++; $display("FAIL edge_write_bresp: %b, required 10", b_resp); end
        read_burst(4'd0, 32'h3FC, 8'd1, 3'd2, BURST_INCR, 0);
        n_tests++;
        if (rd_data[0] !== 32'hC0 || rd_resp[0] !== 2'b00 || rd_data[1] !== 32'h0 || rd_resp[1] !== 2'b10) begin
            n_fail++;
            $display("FAIL edge_read: d0=%h r0=%b d1=%h r1=%b, required 000000c0 00 00000000 10",
                     rd_data[0], rd_resp[0], rd_data[1], rd_resp[1]);
        end
        // reserved burst type on read: every beat errors with zero data
        read_burst(4'd4, 32'h10, 8'd1, 3'd2, 2'b11, 0);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10) begin
                n_fail++; $display("FAIL rsvd_burst_beat%0d: rdata=%h rresp=%b, required 0 10", i, rd_data[i], rd_resp[i]);
            end
        end
        // wlast never asserted: error reported, data still written
        wbuf[0] = 32'hD0; wbuf[1] = 32'hD1;
        write_burst(4'd0, 32'h50, 8'd1, 3'd2, BURST_INCR, 4'hF, 1, b_id, b_resp);
        n_tests++;
        if (b_resp !== 2'b10) begin n_fail++; $display("FAIL wlast_missing_bresp: %b, required 10", b_resp); end
        read_burst(4'd0, 32'h50, 8'd1, 3'd2, BURST_INCR, 0);
        n_tests++;
        if (rd_data[0] !== 32'hD0 || rd_data[1] !== 32'hD1) begin
            n_fail++; $display("FAIL wlast_missing_data: %h %h, required d0 d1", rd_data[0], rd_data[1]);
        end
        // wlast asserted early
        write_burst(4'd0, 32'h58, 8'd1, 3'd2, BURST_INCR, 4'hF, 2, b_id, b_resp);
        n_tests++;
        if (b_resp !== 2'b10) begin n_fail++; $display("FAIL wlast_early_bresp: %b, required 10", b_resp); end
        // WRAP with a length that is not 2/4/8/16 beats
        write_burst(4'd0, 32'h60, 8'd2, 3'd2, BURST_WRAP, 4'hF, 0, b_id, b_resp);
        n_tests++;
        if (b_resp !== 2'b10) begin n_fail++; $display("FAIL wrap_len_bresp: %b, required 10", b_resp); end
        // size wider than the bus
        read_burst(4'd0, 32'h10, 8'd0, 3'd3, BURST_INCR, 0);
        n_tests++;
        if (rd_resp[0] !== 2'b10 || rd_data[0] !== 32'h0) begin
            n_fail++; $display("FAIL size_rresp: rresp=%b rdata=%h, required 10 0", rd_resp[0], rd_data[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        wbuf[0] = 32'h77;
        send_aw(4'd9, 32'h70, 8'd0, 3'd2, BURST_INCR);
        send_w(8'd0, 4'hF, 0);
        bready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (bvalid !== 1'b1 || bid !== 4'd9 || bresp !== 2'b00) begin
                n_fail++; $display("FAIL b_hold%0d: bvalid=%b bid=%h bresp=%b, required 1 9 00", i, bvalid, bid, bresp);
            end
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        n_tests++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            n_fail++; $display("FAIL b_release: bvalid=%b awready=%b, required 0 1", bvalid, awready);
        end
        read_burst(4'd8, 32'h10, 8'd3, 3'd2, BURST_INCR, 1);
        n_tests++;
        if (rd_n != 4 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rtoggle_count: beats=%0d rvalid=%b, required 4 0", rd_n, rvalid);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rd_data[i] !== exp_d[i] || rd_last[i] !== (i == 3)) begin
                n_fail++;
                $display("FAIL rtoggle_beat%0d: rdata=%h rlast=%b, required %h %b", i, rd_data[i], rd_last[i], exp_d[i], (i == 3));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        send_ar(4'd2, 32'h10, 8'd7, 3'd2, BURST_INCR);
        tick(); tick();
        n_tests++;
        if (rvalid !== 1'b1 || rdata !== 32'hA0) begin
            n_fail++; $display("FAIL midrst_pre: rvalid=%b rdata=%h, required 1 a0", rvalid, rdata);
        end
        aresetn = 1'b1;
        tick();
        n_tests++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_in: rvalid=%b rlast=%b arready=%b, required 0 0 0", rvalid, rlast, arready);
        end
        aresetn = 1'b0;
        tick();
        n_tests++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_post: arready=%b rvalid=%b, required 1 0", arready, rvalid);
        end
        read_burst(4'd0, 32'h14, 8'd0, 3'd2, BURST_INCR, 0);
        n_tests++;
        if (rd_data[0] !== 32'hA1) begin n_fail++; $display("FAIL midrst_mem: %h, required a1", rd_data[0]); end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap_read();
        test_fixed();
        test_strobe();
        test_errors();
        test_backpressure();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
